// File: rtl/key_cond_pkg.sv
// Shared definitions for the key conditioner: status-word field offsets,
// key count limit and the per-key auto-repeat state encoding.
package key_cond_pkg;

  localparam int LEVEL_LSB   = 0;
  localparam int PRESS_LSB   = 4;
  localparam int RELEASE_LSB = 8;
  localparam int OVERRUN_LSB = 12;
  localparam int MAX_KEYS    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Button/status bundle between the board keys, the MCU port and the conditioner.
interface key_conditioner_if #(
  parameter int N_KEYS = 4
);
  import key_cond_pkg::*;

  logic [N_KEYS-1:0]   key_sw;
  logic                clr_valid;
  logic [MAX_KEYS-1:0] clr_mask;
  logic [15:0]         port_word;
  logic                key_irq;

  modport master (
    output key_sw,
    output clr_valid,
    output clr_mask,
    input  port_word,
    input  key_irq
  );

  modport slave (
    input  key_sw,
    input  clr_valid,
    input  clr_mask,
    output port_word,
    output key_irq
  );

endinterface

// File: rtl/key_debounce_cell.sv
// One key: two-flop synchroniser, debounce counter, press/release edge
// detection and the auto-repeat state machine.
module key_debounce_cell
  import key_cond_pkg::*;
#(
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_sw_i,
  output logic level_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic repeat_pulse_o
);

  localparam int DB_W    = cnt_width(DB_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = cnt_width(RPT_MAX);
  localparam bit RPT_EN  = (REPEAT_DELAY > 0);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic             sync1_q, sync2_q;
  logic             raw_pressed;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             press_pulse;
  rpt_state_e       state_q, state_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_pulse;

  // Released key idles high, so the synchroniser resets to "not pressed".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_sw_i;
      sync2_q <= sync1_q;
    end
  end

  assign raw_pressed = ~sync2_q;

  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (raw_pressed != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign press_pulse     = level_q & ~level_dly_q;
  assign press_pulse_o   = press_pulse;
  assign release_pulse_o = ~level_q & level_dly_q;

  // A released key always drops back to IDLE without emitting a repeat.
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    rpt_pulse = 1'b0;
    if (!level_q) begin
      state_d   = IDLE;
      rpt_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (RPT_EN && press_pulse) begin
            state_d   = DELAY;
            rpt_cnt_d = '0;
          end
        end
        DELAY: begin
          if (rpt_cnt_q == DELAY_LAST) begin
            rpt_pulse = 1'b1;
            state_d   = REPEAT;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
          end
        end
        REPEAT: begin
          if (rpt_cnt_q == PERIOD_LAST) begin
            rpt_pulse = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt_q    <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      state_q     <= IDLE;
      rpt_cnt_q   <= '0;
    end else begin
      db_cnt_q    <= db_cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      state_q     <= state_d;
      rpt_cnt_q   <= rpt_cnt_d;
    end
  end

  assign level_o        = level_q;
  assign repeat_pulse_o = rpt_pulse;

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key debounce cells feeding sticky, software
// cleared event flags, the packed MCU status word and the press interrupt.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic               clk,
  input  logic               reset_n,
  key_conditioner_if.slave   bus
);

  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press_ev;
  logic [N_KEYS-1:0] release_ev;
  logic [N_KEYS-1:0] clr_sel;
  logic [N_KEYS-1:0] press_q,   press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] overrun_q, overrun_d;
  logic              key_irq_q, key_irq_d;
  logic [15:0]       status_word;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic press_pulse;
    logic repeat_pulse;

    key_debounce_cell #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_cell (
      .clk             (clk),
      .reset_n         (reset_n),
      .key_sw_i        (bus.key_sw[i]),
      .level_o         (level[i]),
      .press_pulse_o   (press_pulse),
      .release_pulse_o (release_ev[i]),
      .repeat_pulse_o  (repeat_pulse)
    );

    assign press_ev[i] = press_pulse | repeat_pulse;
  end

  assign clr_sel = bus.clr_valid ? bus.clr_mask[N_KEYS-1:0] : '0;

  // New events override a simultaneous clear; overrun latches any event that
  // lands on a press flag software has not yet consumed.
  always_comb begin
    press_d   = press_ev | (press_q & ~clr_sel);
    release_d = release_ev | (release_q & ~clr_sel);
    overrun_d = (press_ev & press_q) | (overrun_q & ~clr_sel);
  end

  assign key_irq_d = |press_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_q   <= '0;
      release_q <= '0;
      overrun_q <= '0;
      key_irq_q <= 1'b0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
      overrun_q <= overrun_d;
      key_irq_q <= key_irq_d;
    end
  end

  always_comb begin
    status_word = '0;
    status_word[LEVEL_LSB   +: N_KEYS] = level;
    status_word[PRESS_LSB   +: N_KEYS] = press_q;
    status_word[RELEASE_LSB +: N_KEYS] = release_q;
    status_word[OVERRUN_LSB +: N_KEYS] = overrun_q;
  end

  assign bus.port_word = status_word;
  assign bus.key_irq   = key_irq_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with short debounce/repeat timing
// plus a two-key build for the unused-field checks.
module tb_key_conditioner;
  import key_cond_pkg::*;

  localparam int DB = 8;
  localparam int RD = 32;
  localparam int RP = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  key_conditioner_if #(.N_KEYS(4)) bus ();
  key_conditioner_if #(.N_KEYS(2)) bus2 ();

  key_conditioner #(.N_KEYS(4), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  key_conditioner #(.N_KEYS(2), .DB_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2)
  );

  typedef struct {
    int unsigned at;
    bit          sel2;
    logic [15:0] mask;
    logic [15:0] pw;
    bit          chk_irq;
    logic        irq;
    string       name;
  } exp_t;

  typedef struct {
    logic [3:0]  ksw;
    logic        cv;
    logic [3:0]  cm;
    int          hold;
    logic [15:0] pw;
    logic        irq;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[9];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned edge_cnt = 0;
  logic [15:0] pw_act;
  logic        irq_act;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void cmp(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endfunction

  // Expectations fall due on a given clock edge and are checked half a cycle later.
  always @(negedge clk) begin
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].at == edge_cnt) begin
        pw_act  = sb[k].sel2 ? bus2.port_word : bus.port_word;
        irq_act = sb[k].sel2 ? bus2.key_irq : bus.key_irq;
        if (sb[k].mask != 16'h0000)
          cmp(sb[k].name, pw_act & sb[k].mask, sb[k].pw & sb[k].mask);
        if (sb[k].chk_irq)
          cmp({sb[k].name, "_irq"}, {15'b0, irq_act}, {15'b0, sb[k].irq});
        sb.delete(k);
      end
    end
  end

  task automatic push(input int unsigned dt, input bit sel2, input logic [15:0] mask,
                      input logic [15:0] val, input bit chk_irq, input logic irq,
                      input string name);
    exp_t e;
    e.at = edge_cnt + dt;
    e.sel2 = sel2;
    e.mask = mask;
    e.pw = val;
    e.chk_irq = chk_irq;
    e.irq = irq;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_edge(input int unsigned t);
    while (edge_cnt < t) tick();
  endtask

  task automatic clear(input logic [3:0] m);
    bus.clr_valid = 1'b1;
    bus.clr_mask = m;
    tick();
    bus.clr_valid = 1'b0;
    bus.clr_mask = 4'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned e0;
    int unsigned ef;

    bus.key_sw = 4'hF;  bus.clr_valid = 1'b0;  bus.clr_mask = 4'h0;
    bus2.key_sw = 2'b11; bus2.clr_valid = 1'b0; bus2.clr_mask = 4'h0;
    reset_n = 1'b0;
    tick(3);
    cmp("reset_pw", bus.port_word, 16'h0000);
    cmp("reset_irq", {15'b0, bus.key_irq}, 16'h0000);
    reset_n = 1'b1;

    // Steady-state table: inputs held for 'hold' cycles, clear strobe on the first.
    tbl[0] = '{4'hF, 1'b0, 4'h0,  4, 16'h0000, 1'b0};
    tbl[1] = '{4'hE, 1'b0, 4'h0, 14, 16'h0011, 1'b1};
    tbl[2] = '{4'hF, 1'b0, 4'h0, 14, 16'h0110, 1'b1};
    tbl[3] = '{4'hF, 1'b1, 4'h1,  4, 16'h0000, 1'b0};
    tbl[4] = '{4'hA, 1'b0, 4'h0, 14, 16'h0055, 1'b1};
    tbl[5] = '{4'hA, 1'b1, 4'h1,  4, 16'h0045, 1'b1};
    tbl[6] = '{4'hA, 1'b1, 4'h4,  4, 16'h0005, 1'b0};
    tbl[7] = '{4'hF, 1'b0, 4'h0, 14, 16'h0500, 1'b0};
    tbl[8] = '{4'hF, 1'b1, 4'hF,  4, 16'h0000, 1'b0};
    for (int i = 0; i < 9; i++) begin
      bus.key_sw = tbl[i].ksw;
      bus.clr_valid = tbl[i].cv;
      bus.clr_mask = tbl[i].cm;
      push(tbl[i].hold, 1'b0, 16'hFFFF, tbl[i].pw, 1'b1, tbl[i].irq, $sformatf("vec%0d", i));
      tick();
      bus.clr_valid = 1'b0;
      bus.clr_mask = 4'h0;
      tick(tbl[i].hold - 1);
    end

    // Clean press on key 0: level at +10, press flag at +11, irq at +12.
    bus.key_sw = 4'hE;
    push(9,  1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, "A_lvl_early");
    push(10, 1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0, "A_lvl");
    push(10, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, "A_prs_early");
    push(11, 1'b0, 16'h0010, 16'h0010, 1'b1, 1'b0, "A_prs");
    push(12, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, "A_irq");
    tick(20);
    bus.key_sw = 4'hF;
    tick(14);
    clear(4'hF);
    tick(3);

    // Bounce on key 1, then a clean hold.
    push(10, 1'b0, 16'h0022, 16'h0000, 1'b0, 1'b0, "B_bounce10");
    push(20, 1'b0, 16'h0022, 16'h0000, 1'b0, 1'b0, "B_bounce20");
    push(30, 1'b0, 16'h0022, 16'h0000, 1'b0, 1'b0, "B_bounce30");
    for (int s = 0; s < 10; s++) begin
      bus.key_sw = (s % 2 == 0) ? 4'hD : 4'hF;
      tick(3);
    end
    bus.key_sw = 4'hD;
    push(9,  1'b0, 16'h0002, 16'h0000, 1'b0, 1'b0, "B_lvl_early");
    push(10, 1'b0, 16'h0002, 16'h0002, 1'b0, 1'b0, "B_lvl");
    push(11, 1'b0, 16'h0020, 16'h0020, 1'b0, 1'b0, "B_prs");
    push(20, 1'b0, 16'h2022, 16'h0022, 1'b0, 1'b0, "B_single");
    tick(20);
    bus.key_sw = 4'hF;
    tick(14);
    clear(4'hF);
    tick(3);

    // Clear strobe colliding with a fresh press on key 2.
    bus.key_sw = 4'hB;
    tick(14);
    bus.key_sw = 4'hF;
    tick(14);
    bus.key_sw = 4'hB;
    push(9,  1'b0, 16'h4040, 16'h0040, 1'b0, 1'b0, "C_pre");
    push(12, 1'b0, 16'h4444, 16'h4044, 1'b0, 1'b0, "C_collide");
    tick(10);
    clear(4'h4);
    tick(3);
    bus.key_sw = 4'hF;
    tick(16);
    clear(4'h4);
    push(2, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, "C_cleared");
    tick(3);

    // Auto-repeat on key 3, clearing the press flag after each event.
    e0 = edge_cnt;
    bus.key_sw = 4'h7;
    push(9,  1'b0, 16'h0008, 16'h0000, 1'b0, 1'b0, "D_lvl_early");
    push(10, 1'b0, 16'h0008, 16'h0008, 1'b0, 1'b0, "D_lvl");
    push(42, 1'b0, 16'h8080, 16'h0080, 1'b0, 1'b0, "D_rep0_pre");
    push(43, 1'b0, 16'h8080, 16'h8080, 1'b0, 1'b0, "D_rep0");
    for (int r = 1; r <= 4; r++) begin
      push(42 + 16 * r, 1'b0, 16'h0080, 16'h0000, 1'b0, 1'b0, $sformatf("D_rep%0d_pre", r));
      push(43 + 16 * r, 1'b0, 16'h0080, 16'h0080, 1'b0, 1'b0, $sformatf("D_rep%0d", r));
    end
    for (int r = 0; r <= 4; r++) begin
      wait_edge(e0 + 43 + 16 * r);
      clear(4'h8);
    end
    wait_edge(e0 + 110);
    bus.key_sw = 4'hF;
    push(9,  1'b0, 16'h0008, 16'h0008, 1'b0, 1'b0, "D_held");
    push(10, 1'b0, 16'h0008, 16'h0000, 1'b0, 1'b0, "D_rel_lvl");
    push(11, 1'b0, 16'h0880, 16'h0800, 1'b0, 1'b0, "D_rel");
    push(30, 1'b0, 16'hFFFF, 16'h0800, 1'b1, 1'b0, "D_quiet");
    tick(30);
    clear(4'hF);
    tick(3);

    // Asynchronous reset while key 0 is mid-debounce and key 1 is accepted.
    bus.key_sw = 4'hD;
    tick(14);
    bus.key_sw = 4'hC;
    tick(7);
    cmp("E_pre_rst", bus.port_word, 16'h0022);
    reset_n = 1'b0;
    #1;
    cmp("E_rst_pw", bus.port_word, 16'h0000);
    cmp("E_rst_irq", {15'b0, bus.key_irq}, 16'h0000);
    tick();
    reset_n = 1'b1;
    push(9,  1'b0, 16'h0003, 16'h0000, 1'b0, 1'b0, "E_early");
    push(10, 1'b0, 16'h0003, 16'h0003, 1'b0, 1'b0, "E_accept");
    push(12, 1'b0, 16'hFFFF, 16'h0033, 1'b1, 1'b1, "E_flags");
    tick(14);
    bus.key_sw = 4'hF;
    tick(14);
    clear(4'hF);
    tick(3);

    // Two-key build: upper key fields stay zero whatever is driven.
    ef = edge_cnt;
    bus2.key_sw = 2'b00;
    push(14, 1'b1, 16'hFFFF, 16'h0033, 1'b1, 1'b1, "F_press");
    wait_edge(ef + 14);
    bus2.clr_valid = 1'b1;
    bus2.clr_mask = 4'hF;
    tick();
    bus2.clr_valid = 1'b0;
    bus2.clr_mask = 4'h0;
    push(1, 1'b1, 16'hFFFF, 16'h0003, 1'b1, 1'b0, "F_cleared");
    push(1, 1'b1, 16'hCCCC, 16'h0000, 1'b0, 1'b0, "F_unused");
    tick(4);

    tick(2);
    while (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got no sample want %h", sb[0].name, sb[0].pw);
      void'(sb.pop_front());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
